// File: rtl/vip_scene_recovery.sv
// Haze-removal scene recovery J = A + (I - A)*255/tc, 4-stage pipeline with matched syncs.
// Define SCENE_RECOVERY_STATS_EN to build the per-frame saturated-pixel counter.
module vip_scene_recovery (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic [7:0]  per_img_red,
    input  logic [7:0]  per_img_green,
    input  logic [7:0]  per_img_blue,
    input  logic [7:0]  per_img_trans,
    input  logic [7:0]  atmospheric_light,
    input  logic [7:0]  T_MIN,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic [7:0]  post_img_red,
    output logic [7:0]  post_img_green,
    output logic [7:0]  post_img_blue,
    output logic [19:0] sat_count
);
    localparam int unsigned DW    = 8;
    localparam int unsigned MW    = 16;
    localparam int unsigned QW    = 17;
    localparam int unsigned SW    = 18;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 20;
    localparam int unsigned NCH   = 3;

    logic [DW-1:0]          pix_in [NCH];
    logic [DW-1:0]          tc_c;
    logic [DEPTH-1:0][2:0]  sync_sr;
    logic [DW-1:0]          tc1, tc2, a1, a2, a3;
    logic signed [DW:0]     d1   [NCH];
    logic [MW-1:0]          mag2 [NCH];
    logic                   neg2 [NCH];
    logic signed [QW-1:0]   q3   [NCH];
    logic [DW-1:0]          pix4 [NCH];
    logic [DW-1:0]          abs1_c [NCH];
    logic [MW-1:0]          quot_c [NCH];
    logic [MW-1:0]          div_c;
    logic signed [SW-1:0]   sum_c  [NCH];
    logic [DW-1:0]          clip_c [NCH];

    assign pix_in[0] = per_img_red;
    assign pix_in[1] = per_img_green;
    assign pix_in[2] = per_img_blue;

    // Effective transmission: never below the floor, never zero.
    always_comb begin
        tc_c = per_img_trans;
        if (T_MIN > tc_c) tc_c = T_MIN;
        if (tc_c == '0)   tc_c = DW'(1);
    end

    // Guard keeps the post-reset bubble (tc=0) from producing an X quotient.
    always_comb begin
        div_c = (tc2 == '0) ? MW'(1) : MW'(tc2);
        for (int c = 0; c < NCH; c++) begin
            abs1_c[c] = d1[c][DW] ? DW'(-d1[c]) : DW'(d1[c]);
            quot_c[c] = mag2[c] / div_c;
            sum_c[c]  = SW'($signed({1'b0, a3})) + SW'(q3[c]);
            if (sum_c[c] < SW'(0))
                clip_c[c] = '0;
            else if (sum_c[c] > SW'(255))
                clip_c[c] = '1;
            else
                clip_c[c] = DW'(sum_c[c]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_sr <= '0;
            tc1     <= '0;
            tc2     <= '0;
            a1      <= '0;
            a2      <= '0;
            a3      <= '0;
            for (int c = 0; c < NCH; c++) begin
                d1[c]   <= '0;
                mag2[c] <= '0;
                neg2[c] <= 1'b0;
                q3[c]   <= '0;
                pix4[c] <= '0;
            end
        end else begin
            sync_sr <= {sync_sr[DEPTH-2:0], {per_frame_vsync, per_frame_href, per_frame_clken}};
            tc1     <= tc_c;
            tc2     <= tc1;
            a1      <= atmospheric_light;
            a2      <= a1;
            a3      <= a2;
            for (int c = 0; c < NCH; c++) begin
                d1[c]   <= (DW+1)'($signed({1'b0, pix_in[c]}) - $signed({1'b0, atmospheric_light}));
                mag2[c] <= MW'(abs1_c[c]) * MW'(255);
                neg2[c] <= d1[c][DW];
                q3[c]   <= neg2[c] ? -$signed({1'b0, quot_c[c]}) : $signed({1'b0, quot_c[c]});
                pix4[c] <= clip_c[c];
            end
        end
    end

    assign post_frame_vsync = sync_sr[DEPTH-1][2];
    assign post_frame_href  = sync_sr[DEPTH-1][1];
    assign post_frame_clken = sync_sr[DEPTH-1][0];
    assign post_img_red     = pix4[0];
    assign post_img_green   = pix4[1];
    assign post_img_blue    = pix4[2];

`ifdef SCENE_RECOVERY_STATS_EN
    logic          flag4, vs_prev, any_clip_c, hit_c, fall_c;
    logic [CW-1:0] acc, sat_q, acc_inc_c;

    // Counter saturates at all-ones; the vsync fall captures the frame total.
    always_comb begin
        any_clip_c = 1'b0;
        for (int c = 0; c < NCH; c++)
            if ((sum_c[c] < SW'(0)) || (sum_c[c] > SW'(255))) any_clip_c = 1'b1;
        hit_c     = flag4 & post_frame_clken;
        fall_c    = vs_prev & ~post_frame_vsync;
        acc_inc_c = (acc == '1) ? acc : acc + CW'(hit_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag4   <= 1'b0;
            vs_prev <= 1'b0;
            acc     <= '0;
            sat_q   <= '0;
        end else begin
            flag4   <= any_clip_c;
            vs_prev <= post_frame_vsync;
            if (fall_c) begin
                sat_q <= acc_inc_c;
                acc   <= '0;
            end else begin
                acc   <= acc_inc_c;
            end
        end
    end

    assign sat_count = sat_q;
`else
    assign sat_count = '0;
`endif

endmodule

// File: tb/tb_vip_scene_recovery.sv
// Self-checking bench for vip_scene_recovery: arithmetic reference model plus directed literal cases.
module tb_vip_scene_recovery;
`ifdef SCENE_RECOVERY_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk, rst_n;
    logic        vs, hs, ce;
    logic [7:0]  r, g, b, trans, a_light, t_min;
    logic        post_vs, post_hs, post_ce;
    logic [7:0]  post_r, post_g, post_b;
    logic [19:0] sat_count;

    vip_scene_recovery dut (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(vs), .per_frame_href(hs), .per_frame_clken(ce),
        .per_img_red(r), .per_img_green(g), .per_img_blue(b),
        .per_img_trans(trans), .atmospheric_light(a_light), .T_MIN(t_min),
        .post_frame_vsync(post_vs), .post_frame_href(post_hs), .post_frame_clken(post_ce),
        .post_img_red(post_r), .post_img_green(post_g), .post_img_blue(post_b),
        .sat_count(sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       vs, hs, ce;
        logic [7:0] r, g, b;
        logic       flag;
    } exp_t;

    // Recover one channel; returns {clipped, value}.
    function automatic logic [8:0] rec(input int i, input int a, input int tc);
        int d, m, q, j;
        d = i - a;
        m = (d < 0) ? -d : d;
        q = (m * 255) / tc;
        j = (d < 0) ? a - q : a + q;
        if (j < 0)   return {1'b1, 8'd0};
        if (j > 255) return {1'b1, 8'd255};
        return {1'b0, 8'(j)};
    endfunction

    function automatic exp_t mk();
        exp_t e;
        int tc;
        logic [8:0] cr, cg, cb;
        tc = int'(trans);
        if (int'(t_min) > tc) tc = int'(t_min);
        if (tc < 1) tc = 1;
        cr = rec(int'(r), int'(a_light), tc);
        cg = rec(int'(g), int'(a_light), tc);
        cb = rec(int'(b), int'(a_light), tc);
        e.vs = vs; e.hs = hs; e.ce = ce;
        e.r = cr[7:0]; e.g = cg[7:0]; e.b = cb[7:0];
        e.flag = cr[8] | cg[8] | cb[8];
        return e;
    endfunction

    // Expected outputs delayed by the block's fixed latency.
    exp_t pipe [4];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= mk();
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
    end

    int tests, fails;
    int lit_kind;
    string lit_name;
    logic [7:0]  lit_r, lit_g, lit_b;
    logic [19:0] lit_sat;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Single compare process: model checks every cycle, literal checks when armed.
    initial begin : compare
        exp_t e;
        int   m_cnt, m_sat;
        bit   m_prev, f;
        m_cnt = 0; m_sat = 0; m_prev = 1'b0;
        forever begin
            @(negedge clk);
            e = pipe[3];
            if (!rst_n) begin
                m_cnt = 0; m_sat = 0; m_prev = 1'b0;
            end
            chk("vsync", 32'(post_vs), 32'(e.vs));
            chk("href",  32'(post_hs), 32'(e.hs));
            chk("clken", 32'(post_ce), 32'(e.ce));
            if (e.ce) begin
                chk("red",   32'(post_r), 32'(e.r));
                chk("green", 32'(post_g), 32'(e.g));
                chk("blue",  32'(post_b), 32'(e.b));
            end
            chk("sat_count", 32'(sat_count), 32'(m_sat));
            case (lit_kind)
                1: begin
                    chk({lit_name, " clken"}, 32'(post_ce), 32'd1);
                    chk({lit_name, " red"},   32'(post_r), 32'(lit_r));
                    chk({lit_name, " green"}, 32'(post_g), 32'(lit_g));
                    chk({lit_name, " blue"},  32'(post_b), 32'(lit_b));
                end
                2: chk({lit_name, " clken low"}, 32'(post_ce), 32'd0);
                3: chk({lit_name, " all zero"},
                       32'({post_vs, post_hs, post_ce, post_r, post_g, post_b, sat_count}), 32'd0);
                4: chk({lit_name, " sat_count"}, 32'(sat_count), 32'(lit_sat));
                5: chk({lit_name, " clken high"}, 32'(post_ce), 32'd1);
                default: ;
            endcase
            if (rst_n && STATS) begin
                f = e.ce & e.flag;
                if (m_prev && !e.vs) begin
                    m_sat = (m_cnt + int'(f) > 20'hFFFFF) ? 20'hFFFFF : m_cnt + int'(f);
                    m_cnt = 0;
                end else begin
                    m_cnt = (m_cnt + int'(f) > 20'hFFFFF) ? 20'hFFFFF : m_cnt + int'(f);
                end
                m_prev = e.vs;
            end
        end
    end

    task automatic drv(input logic v, input logic h, input logic c,
                       input logic [7:0] ir, input logic [7:0] ig, input logic [7:0] ib);
        @(negedge clk);
        #1;
        vs = v; hs = h; ce = c; r = ir; g = ig; b = ib;
    endtask

    task automatic lit_pix(input string nm, input logic [7:0] a, input logic [7:0] tm,
                           input logic [7:0] t, input logic [7:0] ir, input logic [7:0] ig,
                           input logic [7:0] ib, input logic [7:0] er, input logic [7:0] eg,
                           input logic [7:0] eb);
        a_light = a; t_min = tm; trans = t;
        drv(1'b0, 1'b1, 1'b1, ir, ig, ib);
        drv(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        lit_name = nm; lit_r = er; lit_g = eg; lit_b = eb; lit_kind = 1;
        @(negedge clk);
        #1 lit_kind = 0;
    endtask

    task automatic lit_sat_frame(input string nm, input logic [7:0] sat_pat, input logic [19:0] exp);
        logic [7:0] v;
        a_light = 8'd200; t_min = 8'd0; trans = 8'd0;
        repeat (2) drv(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        repeat (2) drv(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        repeat (2) drv(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        for (int p = 0; p < 8; p++) begin
            v = sat_pat[p] ? 8'd201 : 8'd200;
            drv((p == 7) ? 1'b0 : 1'b1, 1'b1, 1'b1, v, v, v);
        end
        repeat (6) drv(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        lit_name = nm; lit_sat = exp; lit_kind = 4;
        @(negedge clk);
        #1 lit_kind = 0;
    endtask

    initial begin : stim
        logic v_cur;
        rst_n = 1'b0; lit_kind = 0; lit_name = "";
        lit_r = '0; lit_g = '0; lit_b = '0; lit_sat = '0;
        vs = 0; hs = 0; ce = 0; r = 0; g = 0; b = 0;
        trans = 0; a_light = 0; t_min = 0;
        #1 lit_name = "reset"; lit_kind = 3;
        @(negedge clk);
        #1 lit_kind = 0;
        @(negedge clk);
        #1 rst_n = 1'b1;

        lit_pix("identity",  8'd200, 8'd25, 8'd255, 8'd100, 8'd50,  8'd0,   8'd100, 8'd50,  8'd0);
        lit_pix("truncclip", 8'd200, 8'd25, 8'd128, 8'd100, 8'd50,  8'd200, 8'd1,   8'd0,   8'd200);
        lit_pix("zero_t",    8'd200, 8'd0,  8'd0,   8'd201, 8'd200, 8'd199, 8'd255, 8'd200, 8'd0);
        lit_pix("floor",     8'd200, 8'd64, 8'd10,  8'd210, 8'd190, 8'd200, 8'd239, 8'd161, 8'd200);

        // Randomized traffic against the model.
        v_cur = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                a_light = 8'($urandom_range(0, 255));
                t_min   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 80));
            end
            trans = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) v_cur = ~v_cur;
            drv(v_cur, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        // Mid-line reset, then first pixel must take the full latency.
        a_light = 8'd120; t_min = 8'd30; trans = 8'd90;
        repeat (6) drv(1'b0, 1'b1, 1'b1, 8'($urandom_range(0, 255)), 8'd77, 8'd3);
        #1 rst_n = 1'b0; lit_name = "midreset"; lit_kind = 3;
        @(negedge clk);
        #1 lit_kind = 0;
        @(negedge clk);
        #1 rst_n = 1'b1; vs = 0; hs = 1; ce = 1; r = 8'd10; g = 8'd20; b = 8'd30;
        lit_name = "post_release"; lit_kind = 2;
        repeat (3) @(negedge clk);
        #1 lit_name = "first_pixel"; lit_kind = 5;
        @(negedge clk);
        #1 lit_kind = 0;
        repeat (4) drv(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);

        lit_sat_frame("frame3", 8'b1010_0100, STATS ? 20'd3 : 20'd0);
        lit_sat_frame("frame0", 8'b0000_0000, 20'd0);

        repeat (4) drv(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
